alu_mul_seq: RTL

- Multi-cycle signed 16x16 multiply sequencer that drives the shared 16-bit ALU through its ctrl/a/b port.
- Performs all arithmetic as ALU add, sub and shl operations. The controller only holds registers, compares and muxes.
- Sits beside the ALU in the CPU execute stage; the MUL opcode stalls on busy.
- Returns the low 16 bits of the signed product plus a signed-overflow flag.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply-sequencer state type.
package alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'h0;
  localparam logic [4:0] ALU_SUB = 5'h1;
  localparam logic [4:0] ALU_AND = 5'h2;
  localparam logic [4:0] ALU_OR  = 5'h3;
  localparam logic [4:0] ALU_XOR = 5'h4;
  localparam logic [4:0] ALU_SHL = 5'h5;
  localparam logic [4:0] ALU_SRA = 5'h6;
  localparam logic [4:0] ALU_LLB = 5'h8;
  localparam logic [4:0] ALU_LHB = 5'h9;

  typedef enum logic [2:0] {
    StIdle,
    StAbsA,
    StAbsB,
    StAdd,
    StShift,
    StFix,
    StDone
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Signed 16x16 shift-add multiplier that does all arithmetic on the shared ALU;
// this block only holds registers, compares and muxes ALU operands.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        ovfl,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_ctrl,
  input  logic [15:0] alu_out
);

  localparam int unsigned IdxW = $clog2(ITER);

  mul_state_t      state_q, state_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [15:0]     acc_q, acc_d;
  logic [15:0]     mcand_q, mcand_d;
  logic [15:0]     mplier_q, mplier_d;
  logic            ovf_q, ovf_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic [15:0]     result_q, result_d;
  logic            ovfl_q, ovfl_d;
  logic [IdxW:0]   shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovfl_q   <= ovfl_d;
    end
  end

  // Remaining multiplier bits above the current one; nonzero means a bit
  // shifted out of mcand would still be needed.
  assign shamt = {1'b0, cnt_q} + {{IdxW{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovfl_d   = ovfl_q;
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sgn_d   = op_a[15] ^ op_b[15];
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StAbsA;
        end
      end
      StAbsA: begin
        alu_ctrl = a_q[15] ? ALU_SUB : ALU_ADD;
        alu_b    = a_q;
        mcand_d  = alu_out;
        state_d  = StAbsB;
      end
      StAbsB: begin
        alu_ctrl = b_q[15] ? ALU_SUB : ALU_ADD;
        alu_b    = b_q;
        mplier_d = alu_out;
        state_d  = StAdd;
      end
      StAdd: begin
        alu_a = acc_q;
        alu_b = mplier_q[cnt_q] ? mcand_q : '0;
        acc_d = alu_out;
        if (alu_out < acc_q) ovf_d = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        alu_ctrl = ALU_SHL;
        alu_a    = mcand_q;
        alu_b    = 16'd1;
        mcand_d  = alu_out;
        if (mcand_q[15] && ((mplier_q >> shamt) != '0)) ovf_d = 1'b1;
        cnt_d   = cnt_q + IdxW'(1);
        state_d = (cnt_q == IdxW'(ITER - 1)) ? StFix : StAdd;
      end
      StFix: begin
        alu_ctrl = sgn_q ? ALU_SUB : ALU_ADD;
        alu_b    = acc_q;
        result_d = alu_out;
        // Negative results may reach magnitude 0x8000; positive ones stop at 0x7FFF.
        ovfl_d   = ovf_q | (sgn_q ? (acc_q > 16'h8000) : (acc_q > 16'h7FFF));
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign ovfl   = ovfl_q;

endmodule
